// File: rtl/unlock_sequence_detector_pkg.sv
// Shared anti-theft definitions: unlock FSM state encoding, default timing, counter sizing.
package unlock_sequence_detector_pkg;

  typedef enum logic [1:0] {
    US_IDLE,
    US_COLLECT,
    US_GRANTED,
    US_LOCKOUT
  } unlock_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PRESS_COUNT     = 3;
  localparam int DEF_WINDOW_CYCLES   = 64;
  localparam int DEF_MAX_FAILS       = 3;
  localparam int DEF_LOCKOUT_CYCLES  = 256;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unlock_sequence_detector_input_debouncer.sv
// Single-input debouncer: the clean level follows the raw input only after
// DEBOUNCE_CYCLES consecutive samples that disagree with the current clean level.
module input_debouncer
  import unlock_sequence_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (raw == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      db  <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/unlock_sequence_detector.sv
// Unlock qualifier for the fuel-pump controller: debounces switch and brake,
// checks the hidden-switch press pattern, and locks out after repeated failures.
module unlock_sequence_detector
  import unlock_sequence_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESS_COUNT     = DEF_PRESS_COUNT,
  parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int MAX_FAILS       = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ignition_on,
  input  logic                           hidden_sw_raw,
  input  logic                           brake_raw,
  output logic                           unlock_ok,
  output logic                           brake_clean,
  output logic                           locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output unlock_state_t                  state_dbg
);

  localparam int PCW = $clog2(PRESS_COUNT + 1);
  localparam int WCW = cnt_width(WINDOW_CYCLES);
  localparam int LCW = cnt_width(LOCKOUT_CYCLES);
  localparam int FCW = $clog2(MAX_FAILS + 1);

  logic          sw_db;
  logic          sw_db_q;
  logic          brake_db;
  logic          press;

  unlock_state_t state_q, state_d;
  logic [PCW-1:0] press_cnt_q, press_cnt_d;
  logic [WCW-1:0] win_cnt_q, win_cnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [FCW-1:0] fail_d;
  logic [FCW-1:0] fail_inc;
  logic           do_fail;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (hidden_sw_raw),
    .db    (sw_db)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_brake_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (brake_raw),
    .db    (brake_db)
  );

  assign press       = sw_db & ~sw_db_q;
  assign brake_clean = brake_db;
  assign fail_inc    = fail_count + FCW'(1);

  // Outputs are pure decodes of the state register, so no input reaches them combinationally.
  assign unlock_ok  = (state_q == US_GRANTED);
  assign locked_out = (state_q == US_LOCKOUT);
  assign state_dbg  = state_q;

  // State, counters and the press edge-detect delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= US_IDLE;
      sw_db_q     <= 1'b0;
      press_cnt_q <= '0;
      win_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      fail_count  <= '0;
    end else begin
      state_q     <= state_d;
      sw_db_q     <= sw_db;
      press_cnt_q <= press_cnt_d;
      win_cnt_q   <= win_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      fail_count  <= fail_d;
    end
  end

  // Next-state logic for the pattern checker.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    win_cnt_d   = win_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    fail_d      = fail_count;
    do_fail     = 1'b0;

    case (state_q)
      US_IDLE: begin
        if (ignition_on && brake_db && press) begin
          press_cnt_d = PCW'(1);
          win_cnt_d   = '0;
          state_d     = (PRESS_COUNT == 1) ? US_GRANTED : US_COLLECT;
        end
      end

      US_COLLECT: begin
        // Saturate so a non-completing press on the last window cycle cannot
        // wrap the counter and silently extend the window.
        win_cnt_d = (win_cnt_q == WCW'(WINDOW_CYCLES - 1)) ? win_cnt_q : win_cnt_q + WCW'(1);
        if (!ignition_on || !brake_db) begin
          do_fail = 1'b1;
        end else if (press && ((press_cnt_q + PCW'(1)) == PCW'(PRESS_COUNT))) begin
          state_d = US_GRANTED;
        end else if (press) begin
          press_cnt_d = press_cnt_q + PCW'(1);
        end else if (win_cnt_q == WCW'(WINDOW_CYCLES - 1)) begin
          do_fail = 1'b1;
        end

        if (do_fail) begin
          fail_d = fail_inc;
          if (fail_inc == FCW'(MAX_FAILS)) begin
            state_d    = US_LOCKOUT;
            lock_cnt_d = '0;
          end else begin
            state_d = US_IDLE;
          end
        end
      end

      US_GRANTED: begin
        if (!ignition_on) begin
          state_d = US_IDLE;
          fail_d  = '0;
        end
      end

      US_LOCKOUT: begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
        if (lock_cnt_q == LCW'(LOCKOUT_CYCLES - 1)) begin
          state_d = US_IDLE;
          fail_d  = '0;
        end
      end

      default: state_d = US_IDLE;
    endcase
  end

endmodule

// File: tb/tb_unlock_sequence_detector.sv
// Directed bench for unlock_sequence_detector with default parameters.
module tb_unlock_sequence_detector;
  import unlock_sequence_detector_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          ignition_on;
  logic          hidden_sw_raw;
  logic          brake_raw;
  logic          unlock_ok;
  logic          brake_clean;
  logic          locked_out;
  logic [1:0]    fail_count;
  unlock_state_t state_dbg;

  int checks = 0;
  int passes = 0;

  unlock_sequence_detector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ignition_on   (ignition_on),
    .hidden_sw_raw (hidden_sw_raw),
    .brake_raw     (brake_raw),
    .unlock_ok     (unlock_ok),
    .brake_clean   (brake_clean),
    .locked_out    (locked_out),
    .fail_count    (fail_count),
    .state_dbg     (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // All stimulus changes and all sampling happen on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(6);
  endtask

  // Raw high 5 cycles (press seen by the FSM at the 5th edge), then low 5 cycles.
  task automatic full_press();
    hidden_sw_raw = 1'b1;
    tick(5);
    hidden_sw_raw = 1'b0;
    tick(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ignition_on = 1'b1; brake_raw = 1'b1; hidden_sw_raw = 1'b0;
    tick(2);
    checks++; if (unlock_ok !== 1'b0) $display("FAIL reset_unlock got=%b exp=0", unlock_ok); else passes++;
    checks++; if (locked_out !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked_out); else passes++;
    checks++; if (fail_count !== 2'd0) $display("FAIL reset_fail_count got=%0d exp=0", fail_count); else passes++;
    checks++; if (brake_clean !== 1'b0) $display("FAIL reset_brake got=%b exp=0", brake_clean); else passes++;
    checks++; if (state_dbg !== US_IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    rst_n = 1'b1;
    tick(3);
    checks++; if (brake_clean !== 1'b0) $display("FAIL brake_latency_early got=%b exp=0", brake_clean); else passes++;
    tick(1);
    checks++; if (brake_clean !== 1'b1) $display("FAIL brake_latency_edge4 got=%b exp=1", brake_clean); else passes++;
  endtask

  task automatic test_glitch();
    hidden_sw_raw = 1'b1; tick(2); hidden_sw_raw = 1'b0; tick(6);
    checks++; if (state_dbg !== US_IDLE) $display("FAIL glitch2_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    hidden_sw_raw = 1'b1; tick(3); hidden_sw_raw = 1'b0; tick(6);
    checks++; if (state_dbg !== US_IDLE) $display("FAIL glitch3_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    hidden_sw_raw = 1'b1; tick(4); hidden_sw_raw = 1'b0; tick(1);
    checks++; if (state_dbg !== US_COLLECT) $display("FAIL pulse4_state got=%0d exp=%0d", state_dbg, US_COLLECT); else passes++;
    apply_reset();
  endtask

  task automatic test_unlock();
    for (int p = 0; p < 3; p++) begin
      hidden_sw_raw = 1'b1;
      tick(4);
      checks++; if (unlock_ok !== 1'b0) $display("FAIL unlock_early p=%0d got=%b exp=0", p, unlock_ok); else passes++;
      tick(1);
      checks++;
      if (state_dbg !== ((p == 2) ? US_GRANTED : US_COLLECT))
        $display("FAIL unlock_state p=%0d got=%0d", p, state_dbg);
      else passes++;
      checks++; if (unlock_ok !== (p == 2)) $display("FAIL unlock_level p=%0d got=%b exp=%b", p, unlock_ok, (p == 2)); else passes++;
      hidden_sw_raw = 1'b0;
      tick(5);
    end
    brake_raw = 1'b0; tick(6);
    full_press();
    checks++; if (unlock_ok !== 1'b1) $display("FAIL granted_ignores_inputs got=%b exp=1", unlock_ok); else passes++;
    brake_raw = 1'b1; tick(6);
    ignition_on = 1'b0; tick(1);
    checks++; if (unlock_ok !== 1'b0) $display("FAIL ignition_drop_unlock got=%b exp=0", unlock_ok); else passes++;
    checks++; if (state_dbg !== US_IDLE) $display("FAIL ignition_drop_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    ignition_on = 1'b1; tick(2);
  endtask

  task automatic test_window();
    // Timeout: first press accepted at edge E; FAIL lands at E+64.
    full_press(); full_press();
    tick(48);
    checks++; if (state_dbg !== US_COLLECT) $display("FAIL window_e63_state got=%0d exp=%0d", state_dbg, US_COLLECT); else passes++;
    tick(1);
    checks++; if (state_dbg !== US_IDLE) $display("FAIL window_timeout_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    checks++; if (fail_count !== 2'd1) $display("FAIL window_timeout_fails got=%0d exp=1", fail_count); else passes++;
    // Completing press sampled on the last window cycle wins over the timeout.
    full_press(); full_press();
    tick(44);
    hidden_sw_raw = 1'b1;
    tick(4);
    checks++; if (state_dbg !== US_COLLECT) $display("FAIL window_last_pre got=%0d exp=%0d", state_dbg, US_COLLECT); else passes++;
    tick(1);
    checks++; if (state_dbg !== US_GRANTED) $display("FAIL window_last_grant got=%0d exp=%0d", state_dbg, US_GRANTED); else passes++;
    checks++; if (fail_count !== 2'd1) $display("FAIL granted_keeps_fails got=%0d exp=1", fail_count); else passes++;
    hidden_sw_raw = 1'b0; ignition_on = 1'b0; tick(1);
    checks++; if (fail_count !== 2'd0) $display("FAIL leave_granted_clears got=%0d exp=0", fail_count); else passes++;
    tick(5);
    ignition_on = 1'b1; tick(1);
  endtask

  task automatic test_brake_fail();
    full_press(); full_press();
    brake_raw = 1'b0; tick(3);
    checks++; if (brake_clean !== 1'b1) $display("FAIL brake_fall_early got=%b exp=1", brake_clean); else passes++;
    tick(1);
    checks++; if (brake_clean !== 1'b0) $display("FAIL brake_fall_edge4 got=%b exp=0", brake_clean); else passes++;
    tick(1);
    checks++; if (state_dbg !== US_IDLE) $display("FAIL brake_fail_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    checks++; if (fail_count !== 2'd1) $display("FAIL brake_fail_count got=%0d exp=1", fail_count); else passes++;
    brake_raw = 1'b1; tick(6);
    full_press(); full_press();
    hidden_sw_raw = 1'b1; brake_raw = 1'b0; tick(5);
    checks++; if (state_dbg !== US_IDLE) $display("FAIL coincident_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    checks++; if (fail_count !== 2'd2) $display("FAIL coincident_count got=%0d exp=2", fail_count); else passes++;
    checks++; if (unlock_ok !== 1'b0) $display("FAIL coincident_unlock got=%b exp=0", unlock_ok); else passes++;
    hidden_sw_raw = 1'b0; brake_raw = 1'b1; tick(6);
  endtask

  task automatic three_fails();
    for (int i = 0; i < 3; i++) begin
      hidden_sw_raw = 1'b1; tick(5);
      ignition_on = 1'b0; tick(1);
      checks++; if (fail_count !== 2'(i + 1)) $display("FAIL fails_step i=%0d got=%0d exp=%0d", i, fail_count, i + 1); else passes++;
      checks++; if (locked_out !== (i == 2)) $display("FAIL locked_step i=%0d got=%b exp=%b", i, locked_out, (i == 2)); else passes++;
      ignition_on = 1'b1; hidden_sw_raw = 1'b0; tick(5);
    end
  endtask

  task automatic test_lockout();
    apply_reset();
    three_fails();
    // Now at lockout entry edge L + 5.
    full_press(); full_press(); full_press();
    ignition_on = 1'b0; tick(3); ignition_on = 1'b1; tick(3);
    full_press(); full_press(); full_press();
    checks++; if (state_dbg !== US_LOCKOUT) $display("FAIL lockout_holds got=%0d exp=%0d", state_dbg, US_LOCKOUT); else passes++;
    checks++; if (unlock_ok !== 1'b0) $display("FAIL lockout_no_unlock got=%b exp=0", unlock_ok); else passes++;
    tick(184);
    checks++; if (locked_out !== 1'b1) $display("FAIL lockout_last_cycle got=%b exp=1", locked_out); else passes++;
    tick(1);
    checks++; if (locked_out !== 1'b0) $display("FAIL lockout_expired got=%b exp=0", locked_out); else passes++;
    checks++; if (state_dbg !== US_IDLE) $display("FAIL lockout_exit_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    checks++; if (fail_count !== 2'd0) $display("FAIL lockout_exit_fails got=%0d exp=0", fail_count); else passes++;
  endtask

  task automatic test_reset_mid();
    hidden_sw_raw = 1'b1; tick(5);
    ignition_on = 1'b0; tick(1);
    ignition_on = 1'b1; hidden_sw_raw = 1'b0; tick(5);
    full_press(); full_press(); full_press();
    checks++; if (state_dbg !== US_GRANTED) $display("FAIL pre_reset_granted got=%0d exp=%0d", state_dbg, US_GRANTED); else passes++;
    checks++; if (fail_count !== 2'd1) $display("FAIL pre_reset_fails got=%0d exp=1", fail_count); else passes++;
    rst_n = 1'b0; tick(1);
    checks++; if (unlock_ok !== 1'b0) $display("FAIL rst_granted_unlock got=%b exp=0", unlock_ok); else passes++;
    checks++; if (state_dbg !== US_IDLE) $display("FAIL rst_granted_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    checks++; if (fail_count !== 2'd0) $display("FAIL rst_granted_fails got=%0d exp=0", fail_count); else passes++;
    checks++; if (brake_clean !== 1'b0) $display("FAIL rst_granted_brake got=%b exp=0", brake_clean); else passes++;
    rst_n = 1'b1; tick(6);
    three_fails();
    tick(10);
    rst_n = 1'b0; tick(1);
    checks++; if (locked_out !== 1'b0) $display("FAIL rst_lockout_locked got=%b exp=0", locked_out); else passes++;
    checks++; if (state_dbg !== US_IDLE) $display("FAIL rst_lockout_state got=%0d exp=%0d", state_dbg, US_IDLE); else passes++;
    checks++; if (fail_count !== 2'd0) $display("FAIL rst_lockout_fails got=%0d exp=0", fail_count); else passes++;
    rst_n = 1'b1; tick(6);
  endtask

  initial begin
    rst_n = 1'b0; ignition_on = 1'b0; hidden_sw_raw = 1'b0; brake_raw = 1'b0;
    test_reset();
    test_glitch();
    test_unlock();
    test_window();
    test_brake_fail();
    test_lockout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
